shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Sequential right shifter, the counterpart of the team's combinational 4-bit left shifter. It loads a word on a start strobe and shifts it right one bit position per clock, for a requested number of positions, with logical (zero-fill) or arithmetic (sign-fill) mode. It exposes each shifted-out bit serially and reports completion with a busy/done handshake. It sits beside the left shifter in the arithmetic exercise set and shares its 4-bit data width by default.

## Interface
- `WIDTH`, default 4: data width in bits (≥2).
- `CNT_W`, default 3: width of `amount`; must hold the value WIDTH.
- `clk`  in  1: clock, all state changes on rising edge.
- `reset`  in  1: reset, synchronous and active-high.
- `start`  in  1: request. Sampled only in IDLE.
- `load_data`  in  WIDTH: operand, captured with `start`.
- `amount`  in  CNT_W: number of positions to shift, captured with `start`. Values above WIDTH are clamped to WIDTH.
- `arith`  in  1: fill mode, captured with `start`. 1 = fill with the operand MSB; 0 = fill with zero.
- `result`  out  WIDTH: final shifted word. Registered; holds until the next completion.
- `serial_out`  out  1: the bit shifted out on the most recent shift edge (old LSB). Registered.
- `busy`  out  1: high while state ≠ IDLE.
- `done`  out  1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding is binary 2-bit.
- **IDLE**
  - If `start`=1 at an edge: `shreg`←`load_data`; `cnt`←min(`amount`, WIDTH); `fill`←`arith` & `load_data`[WIDTH-1].
  - Next state is DONE if the clamped count is 0, otherwise SHIFT.
- **SHIFT**, each edge:
  - `shreg`←{`fill`, `shreg`[WIDTH-1:1]}.
  - `serial_out`←`shreg`[0].
  - `cnt`←`cnt`−1.
  - If `cnt`==1 before the decrement, the next state is DONE.
- **Entering DONE**
  - `result` takes the final shifted value (that is, the `shreg` value after the last shift).
  - `done`=1 for exactly the one cycle spent in DONE.
- **DONE**: the next edge returns to IDLE unconditionally. `start` is ignored in DONE.
- `start` in SHIFT or DONE is ignored; it is not queued.
- Arithmetic shift by ≥WIDTH gives all-ones for a negative operand and zero otherwise. Logical shift by ≥WIDTH gives zero.
- Reset values: `result`=0, `serial_out`=0, `busy`=0, `done`=0, state=IDLE, `cnt`=0, `shreg`=0.

## Timing
- Let E0 be the edge that samples `start` in IDLE.
  - `busy` rises after E0.
  - Shifts occur on edges E1..EN, where N is the clamped amount.
  - DONE is entered after edge EN (after E0 when N=0).
  - `done` and the new `result` are visible in the cycle following EN.
  - `busy` falls after edge EN+1.
- Total occupancy is N+1 cycles. The next `start` is accepted at the first edge where the state is IDLE, so back-to-back operation costs N+2 edges per operation.
- `serial_out` changes only on shift edges and holds otherwise.
- Reset mid-operation: all state and outputs return to their reset values at the next edge, regardless of state. An in-flight operation is discarded with no `done`.
- Reset and `start` at the same edge: reset wins.

## Structure
- Shared package `shift_pkg`:
  - state localparams `S_IDLE`, `S_SHIFT`, `S_DONE`;
  - default `WIDTH` constant, shared with the left shifter.
- One natural combinational sub-module, `shift_right_step`: a one-position right shift with a fill-bit input, mirroring the left shifter's role.
- Counter, FSM and output registers live in the top module.

## Test plan
- Logical shift: `load_data`=4'b1011, `amount`=2, `arith`=0 → `serial_out` 1 then 1, `result`=4'b0010, `done` in the cycle after E2, `busy` high for 3 cycles.
- Arithmetic shift: `load_data`=4'b1011, `amount`=2, `arith`=1 → `result`=4'b1110. Repeating with `load_data`=4'b0110 → `result`=4'b0001.
- Zero and clamped amounts:
  - `amount`=0 → `done` after E0 with `result`=`load_data`.
  - `amount`=7 with 4'b1001 → `result` 4'b0000 (logical) and 4'b1111 (arith), each after 4 shifts.
- Start while busy: pulse `start` with new data during SHIFT and during DONE → ignored; `result` reflects only the first operation; exactly one `done`.
- Reset mid-shift: `amount`=4, assert `reset` at E2 → all outputs 0 after that edge, no `done`. A new `start` afterwards completes normally.
- Exhaustive sweep: all 16 operands × amounts 0..4 × both modes, compared against a reference model of `>>` / `>>>`.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shifter constants and FSM state encoding
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_step.sv
// rtl/shift_right_step.sv - one-position right shift with explicit fill bit
module shift_right_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    assign dout = {fill, din[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - sequential right shifter, one position per clock
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] amount,
    input  logic             arith,
    output logic [WIDTH-1:0] result,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] amt_clamped;
    logic             fill;

    assign amt_clamped = (amount > MAX_CNT) ? MAX_CNT : amount;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .din  (shreg),
        .fill (fill),
        .dout (shreg_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            fill       <= 1'b0;
            result     <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg <= load_data;
                        cnt   <= amt_clamped;
                        fill  <= arith & load_data[WIDTH-1];
                        busy  <= 1'b1;
                        // A zero-length request completes without touching serial_out.
                        if (amt_clamped == '0) begin
                            state  <= S_DONE;
                            result <= load_data;
                            done   <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    shreg      <= shreg_next;
                    serial_out <= shreg[0];
                    cnt        <= cnt - ONE_CNT;
                    if (cnt == ONE_CNT) begin
                        state  <= S_DONE;
                        result <= shreg_next;
                        done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// tb/tb_shift_right_seq.sv - directed and swept checks for shift_right_seq
module tb_shift_right_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] load_data;
    logic [2:0] amount;
    logic       arith;
    logic [3:0] result;
    logic       serial_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    shift_right_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_data  (load_data),
        .amount     (amount),
        .arith      (arith),
        .result     (result),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [3:0] data;
        logic [2:0] amt;
        logic       ar;
        logic [3:0] exp_result;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input logic [2:0] a);
        return (a > 3'd4) ? 4 : int'(a);
    endfunction

    function automatic logic [3:0] model(input logic [3:0] d, input logic [2:0] a, input logic ar);
        logic [3:0] r;
        int n;
        n = clamp(a);
        if (ar) r = $signed(d) >>> n;
        else    r = d >> n;
        return r;
    endfunction

    // Issues one request and watches it until busy drops; sample k follows edge Ek.
    task automatic do_op(input logic [3:0] d, input logic [2:0] a, input logic ar,
                         output logic [3:0] res, output int lat, output int busy_cyc,
                         output int dones, output logic [15:0] ser);
        int d0;
        @(negedge clk);
        load_data = d; amount = a; arith = ar; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; busy_cyc = 0; ser = '0; res = '0;
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            ser[i] = serial_out;
            if (busy) busy_cyc++;
            if (done && lat < 0) begin
                lat = i;
                res = result;
            end
            if (!busy) break;
            @(negedge clk);
        end
        dones = done_cnt - d0;
    endtask

    vec_t vecs[8];
    logic [3:0]  res;
    logic [15:0] ser;
    int lat, bcyc, dn, n, d0;

    initial begin
        vecs[0] = '{4'b1011, 3'd2, 1'b0, 4'b0010};
        vecs[1] = '{4'b1011, 3'd2, 1'b1, 4'b1110};
        vecs[2] = '{4'b0110, 3'd2, 1'b1, 4'b0001};
        vecs[3] = '{4'b1011, 3'd0, 1'b0, 4'b1011};
        vecs[4] = '{4'b1001, 3'd7, 1'b0, 4'b0000};
        vecs[5] = '{4'b1001, 3'd7, 1'b1, 4'b1111};
        vecs[6] = '{4'b1001, 3'd4, 1'b1, 4'b1111};
        vecs[7] = '{4'b0111, 3'd1, 1'b1, 4'b0011};

        reset = 1'b1; start = 1'b0; load_data = '0; amount = '0; arith = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_result", result, 0);
        chk("reset_serial", serial_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].data, vecs[i].amt, vecs[i].ar, res, lat, bcyc, dn, ser);
            n = clamp(vecs[i].amt);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_result);
            chk($sformatf("vec%0d_latency", i), lat, n);
            chk($sformatf("vec%0d_busy_cycles", i), bcyc, n + 1);
            chk($sformatf("vec%0d_done_count", i), dn, 1);
            if (i == 0) begin
                chk("logic_serial_e1", ser[1], 1);
                chk("logic_serial_e2", ser[2], 1);
            end
        end

        // Start pulses during SHIFT and DONE must be dropped.
        d0 = done_cnt;
        @(negedge clk);
        load_data = 4'b1011; amount = 3'd2; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        load_data = 4'b0101; amount = 3'd0; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_start_done_pulse", done, 1);
        chk("busy_start_result", result, 4'b0010);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_idle_busy", busy, 0);
        @(negedge clk);
        chk("busy_start_not_queued", busy, 0);
        chk("busy_start_one_done", done_cnt - d0, 1);

        // Reset sampled at E2 of a 4-position shift.
        d0 = done_cnt;
        @(negedge clk);
        load_data = 4'b1011; amount = 3'd4; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_result", result, 0);
        chk("midreset_serial", serial_out, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        repeat (5) @(negedge clk);
        chk("midreset_no_done", done_cnt - d0, 0);
        do_op(4'b1100, 3'd1, 1'b1, res, lat, bcyc, dn, ser);
        chk("after_reset_result", res, 4'b1110);
        chk("after_reset_done_count", dn, 1);

        // Reset and start at the same edge: reset wins.
        @(negedge clk);
        load_data = 4'b1111; amount = 3'd3; arith = 1'b1; start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("reset_vs_start_busy", busy, 0);
        chk("reset_vs_start_result", result, 0);

        for (int d = 0; d < 16; d++)
            for (int a = 0; a <= 4; a++)
                for (int m = 0; m < 2; m++) begin
                    do_op(4'(d), 3'(a), 1'(m), res, lat, bcyc, dn, ser);
                    chk($sformatf("sweep_d%0d_a%0d_m%0d", d, a, m), res, model(4'(d), 3'(a), 1'(m)));
                    chk($sformatf("sweep_lat_d%0d_a%0d_m%0d", d, a, m), lat, a);
                end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
